// File: rtl/demux2_reg.sv
// demux2_reg: registered 1-to-2 demultiplexer with a single valid/ready slot per output.
// Define DEMUX2_COUNT_EN to add the A_count/B_count delivered-word counters.
module demux2_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [15:0]      A_count,
  output logic [15:0]      B_count
`endif
);

  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic             a_take, b_take;
  logic             in_fire, a_load, b_load;

  assign a_take = a_valid_q & A_ready;
  assign b_take = b_valid_q & B_ready;

  // A slot that is draining this cycle can be reloaded in the same cycle; the other slot is ignored.
  assign in_ready = ~reset & (sel ? (~b_valid_q | B_ready) : (~a_valid_q | A_ready));
  assign in_fire  = in_valid & in_ready;
  assign a_load   = in_fire & ~sel;
  assign b_load   = in_fire & sel;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred on the hold paths.
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    if (a_load) begin
      a_data_d  = in_data;
      a_valid_d = 1'b1;
    end else if (a_take) begin
      a_valid_d = 1'b0;
    end
    if (b_load) begin
      b_data_d  = in_data;
      b_valid_d = 1'b1;
    end else if (b_take) begin
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: payload registers are reset too, because A and B must read zero after reset.
    if (reset) begin
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign A       = a_data_q;
  assign A_valid = a_valid_q;
  assign B       = b_data_q;
  assign B_valid = b_valid_q;

`ifdef DEMUX2_COUNT_EN
  logic [15:0] a_count_q, b_count_q;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_count_q <= 16'h0000;
      b_count_q <= 16'h0000;
    end else begin
      if (a_take) a_count_q <= a_count_q + 16'd1;
      if (b_take) b_count_q <= b_count_q + 16'd1;
    end
  end

  assign A_count = a_count_q;
  assign B_count = b_count_q;
`endif

endmodule
